freqdiv_prog_multi: RTL and testbench

//  Programmable multi-channel clock divider for the speaker/tone path and slow UI timers.

---
 rtl/freqdiv_prog_multi.sv | 97 +++++++++
 tb/tb_freqdiv_prog_multi.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freqdiv_prog_multi.sv
// Multi-channel programmable clock divider: each channel emits a 50% square wave
// and a toggle tick, with half-period changes applied only at a terminal count.
module freqdiv_prog_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 27,
  parameter int DEF_HP = 12500000,
  localparam int AW    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic [CNT_W-1:0]  cfg_rdata,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] HP_DEF = CNT_W'(DEF_HP);
  localparam logic [CNT_W-1:0] HP_ONE = CNT_W'(1);

  // Terminal count: last cycle of the current half-period of a running channel.
  function automatic logic is_terminal(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] hp);
    return (hp != '0) && (cnt == hp - HP_ONE);
  endfunction

  // Extra MSB so the range check stays meaningful when NUM_CH is a power of two.
  logic addr_ok;
  assign addr_ok = ({1'b0, cfg_addr} < (AW+1)'(NUM_CH));

  logic [CNT_W-1:0] act_hp_all [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] pend_hp;
    logic [CNT_W-1:0] act_hp;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_pend;
    logic             wr_hit;
    logic             clk_q;
    logic             tick_q;

    assign wr_hit    = cfg_we && addr_ok && (cfg_addr == AW'(i));
    assign next_pend = wr_hit ? cfg_wdata : pend_hp;

    always_ff @(posedge clk) begin
      if (rst) begin
        pend_hp <= HP_DEF;
        act_hp  <= HP_DEF;
        cnt     <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        pend_hp <= next_pend;
        if (sync_restart) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          act_hp <= next_pend;
        end else if (!ch_en[i]) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          act_hp <= pend_hp;
        end else if (act_hp == '0) begin
          // Stopped channel stays parked until disable or sync_restart reloads it.
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (is_terminal(cnt, act_hp)) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          tick_q <= 1'b1;
          act_hp <= next_pend;
        end else begin
          cnt    <= cnt + HP_ONE;
          tick_q <= 1'b0;
        end
      end
    end

    assign act_hp_all[i] = act_hp;
    assign clk_out[i]    = clk_q;
    assign tick[i]       = tick_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rdata <= '0;
    end else begin
      cfg_rdata <= addr_ok ? act_hp_all[cfg_addr] : '0;
    end
  end

endmodule

// File: tb/tb_freqdiv_prog_multi.sv
// Directed bench for freqdiv_prog_multi (NUM_CH=2, CNT_W=8, DEF_HP=3), plus a
// three-channel instance to exercise an out-of-range config address.
module tb_freqdiv_prog_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ch_en = '0;
  logic       sync_restart = 1'b0;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;
  logic [1:0] clk_out;
  logic [1:0] tick;

  logic       b_rst = 1'b1;
  logic [2:0] b_en = '0;
  logic       b_we = 1'b0;
  logic [1:0] b_addr = '0;
  logic [7:0] b_wdata = '0;
  logic [7:0] b_rdata;
  logic [2:0] b_clk_out;
  logic [2:0] b_tick;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  freqdiv_prog_multi #(.NUM_CH(2), .CNT_W(8), .DEF_HP(3)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .sync_restart(sync_restart),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .clk_out(clk_out), .tick(tick)
  );

  freqdiv_prog_multi #(.NUM_CH(3), .CNT_W(8), .DEF_HP(3)) dut_b (
    .clk(clk), .rst(b_rst), .ch_en(b_en), .sync_restart(1'b0),
    .cfg_we(b_we), .cfg_addr(b_addr), .cfg_wdata(b_wdata),
    .cfg_rdata(b_rdata), .clk_out(b_clk_out), .tick(b_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b_rst = 1'b1;
    step();
    step();
    checks++;
    if ({clk_out, tick} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got clk_out=%b tick=%b expected 00/00", clk_out, tick);
    end
    checks++;
    if (cfg_rdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %0d expected 0", cfg_rdata);
    end
  endtask

  task automatic test_default_run();
    logic [1:0] exp;
    rst = 1'b0;
    ch_en = 2'b01;
    cfg_addr = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {((k / 3) % 2) == 1, (k % 3) == 0};
      checks++;
      if ({clk_out[0], tick[0]} !== exp) begin
        errors++;
        $display("FAIL run_ch0 edge %0d: got clk/tick=%b expected %b", k, {clk_out[0], tick[0]}, exp);
      end
      checks++;
      if ({clk_out[1], tick[1]} !== 2'b00) begin
        errors++;
        $display("FAIL run_ch1_idle edge %0d: got clk/tick=%b expected 00", k, {clk_out[1], tick[1]});
      end
      checks++;
      if (cfg_rdata !== 8'd3) begin
        errors++;
        $display("FAIL run_rdata edge %0d: got %0d expected 3", k, cfg_rdata);
      end
    end
  endtask

  task automatic test_midperiod_write();
    logic [1:0] exp;
    logic [7:0] exp_rd;
    step();
    cfg_we = 1'b1;
    cfg_addr = 1'b0;
    cfg_wdata = 8'd5;
    step();
    cfg_we = 1'b0;
    checks++;
    if ({clk_out[0], tick[0], cfg_rdata} !== {2'b00, 8'd3}) begin
      errors++;
      $display("FAIL midwrite_commit: got clk/tick=%b rdata=%0d expected 00 rdata=3", {clk_out[0], tick[0]}, cfg_rdata);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      exp = {k < 6, (k == 1) || (k == 6)};
      exp_rd = (k == 1) ? 8'd3 : 8'd5;
      checks++;
      if ({clk_out[0], tick[0]} !== exp) begin
        errors++;
        $display("FAIL midwrite_ch0 edge %0d: got clk/tick=%b expected %b", k, {clk_out[0], tick[0]}, exp);
      end
      checks++;
      if (cfg_rdata !== exp_rd) begin
        errors++;
        $display("FAIL midwrite_rdata edge %0d: got %0d expected %0d", k, cfg_rdata, exp_rd);
      end
    end
  endtask

  task automatic test_terminal_bypass();
    logic [1:0] exp;
    for (int k = 1; k <= 4; k++) step();
    checks++;
    if ({clk_out[0], tick[0]} !== 2'b00) begin
      errors++;
      $display("FAIL bypass_pre: got clk/tick=%b expected 00", {clk_out[0], tick[0]});
    end
    cfg_we = 1'b1;
    cfg_wdata = 8'd7;
    step();
    cfg_we = 1'b0;
    checks++;
    if ({clk_out[0], tick[0]} !== 2'b11) begin
      errors++;
      $display("FAIL bypass_toggle: got clk/tick=%b expected 11", {clk_out[0], tick[0]});
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      exp = {k < 7, k == 7};
      checks++;
      if ({clk_out[0], tick[0], cfg_rdata} !== {exp, 8'd7}) begin
        errors++;
        $display("FAIL bypass_half edge %0d: got clk/tick=%b rdata=%0d expected %b rdata=7", k, {clk_out[0], tick[0]}, cfg_rdata, exp);
      end
    end
  endtask

  task automatic test_zero_halfperiod();
    ch_en = 2'b11;
    cfg_we = 1'b1;
    cfg_addr = 1'b1;
    cfg_wdata = 8'd0;
    step();
    cfg_we = 1'b0;
    step();
    checks++;
    if ({clk_out[1], tick[1], cfg_rdata} !== {2'b00, 8'd3}) begin
      errors++;
      $display("FAIL zero_pre: got clk/tick=%b rdata=%0d expected 00 rdata=3", {clk_out[1], tick[1]}, cfg_rdata);
    end
    step();
    checks++;
    if ({clk_out[1], tick[1]} !== 2'b11) begin
      errors++;
      $display("FAIL zero_last_toggle: got clk/tick=%b expected 11", {clk_out[1], tick[1]});
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if ({clk_out[1], tick[1], cfg_rdata} !== {2'b00, 8'd0}) begin
        errors++;
        $display("FAIL zero_hold edge %0d: got clk/tick=%b rdata=%0d expected 00 rdata=0", k, {clk_out[1], tick[1]}, cfg_rdata);
      end
    end
    cfg_we = 1'b1;
    cfg_wdata = 8'd2;
    step();
    cfg_we = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if ({clk_out[1], tick[1], cfg_rdata} !== {2'b00, 8'd0}) begin
        errors++;
        $display("FAIL zero_no_restart edge %0d: got clk/tick=%b rdata=%0d expected 00 rdata=0", k, {clk_out[1], tick[1]}, cfg_rdata);
      end
    end
    ch_en = 2'b01;
    step();
    ch_en = 2'b11;
    step();
    checks++;
    if ({clk_out[1], tick[1], cfg_rdata} !== {2'b00, 8'd2}) begin
      errors++;
      $display("FAIL reenable_first: got clk/tick=%b rdata=%0d expected 00 rdata=2", {clk_out[1], tick[1]}, cfg_rdata);
    end
    step();
    checks++;
    if ({clk_out[1], tick[1]} !== 2'b11) begin
      errors++;
      $display("FAIL reenable_toggle: got clk/tick=%b expected 11", {clk_out[1], tick[1]});
    end
  endtask

  task automatic test_sync_restart();
    logic [3:0] exp;
    cfg_we = 1'b1;
    cfg_addr = 1'b0;
    cfg_wdata = 8'd3;
    step();
    cfg_addr = 1'b1;
    cfg_wdata = 8'd4;
    sync_restart = 1'b1;
    step();
    cfg_we = 1'b0;
    sync_restart = 1'b0;
    checks++;
    if ({clk_out, tick} !== 4'b0000) begin
      errors++;
      $display("FAIL sync_clear: got clk_out=%b tick=%b expected 00/00", clk_out, tick);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {((k / 4) % 2) == 1, ((k / 3) % 2) == 1, (k % 4) == 0, (k % 3) == 0};
      checks++;
      if ({clk_out, tick} !== exp) begin
        errors++;
        $display("FAIL sync_phase edge %0d: got clk_out/tick=%b expected %b", k, {clk_out, tick}, exp);
      end
    end
    checks++;
    if (cfg_rdata !== 8'd4) begin
      errors++;
      $display("FAIL sync_bypass_rdata: got %0d expected 4", cfg_rdata);
    end
  endtask

  task automatic test_reset_midrun();
    logic [1:0] exp;
    cfg_we = 1'b1;
    cfg_addr = 1'b0;
    cfg_wdata = 8'd9;
    step();
    cfg_we = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({clk_out, tick, cfg_rdata} !== {4'b0000, 8'd0}) begin
      errors++;
      $display("FAIL midrun_reset: got clk_out=%b tick=%b rdata=%0d expected 00/00 rdata=0", clk_out, tick, cfg_rdata);
    end
    rst = 1'b0;
    ch_en = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp = {(k >= 3) && (k < 6), (k % 3) == 0};
      checks++;
      if ({clk_out, tick, cfg_rdata} !== {1'b0, exp[1], 1'b0, exp[0], 8'd3}) begin
        errors++;
        $display("FAIL post_reset edge %0d: got clk_out=%b tick=%b rdata=%0d expected ch0 clk/tick=%b rdata=3", k, clk_out, tick, cfg_rdata, exp);
      end
    end
  endtask

  task automatic test_bad_addr();
    logic [2:0] exp;
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    b_en = 3'b111;
    b_we = 1'b1;
    b_addr = 2'd3;
    b_wdata = 8'd1;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp = ((k >= 3) && (k < 6)) ? 3'b111 : 3'b000;
      checks++;
      if ({b_clk_out, b_rdata} !== {exp, 8'd0}) begin
        errors++;
        $display("FAIL bad_addr edge %0d: got clk_out=%b rdata=%0d expected %b rdata=0", k, b_clk_out, b_rdata, exp);
      end
    end
    b_we = 1'b0;
    for (int a = 0; a < 3; a++) begin
      b_addr = 2'(a);
      step();
      checks++;
      if (b_rdata !== 8'd3) begin
        errors++;
        $display("FAIL bad_addr_readback ch%0d: got %0d expected 3", a, b_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_midperiod_write();
    test_terminal_bypass();
    test_zero_halfperiod();
    test_sync_restart();
    test_reset_midrun();
    test_bad_addr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
